fifo_top: RTL and testbench

Self-exercising synchronous FIFO block for FPGA bring-up. It integrates a parameterised FIFO, an internal traffic generator and an optional data checker, so it needs only a clock and reset from the board. After reset it runs a fixed fill / drain / streaming sequence and reports the result on status outputs for LEDs or an ILA.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo.sv | 61 ++++++
 rtl/fifo_top.sv | 136 +++++++++++++
 tb/tb_fifo_top.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the self-exercising FIFO block.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    // Traffic generator phases, in the order the run visits them.
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        STREAM,
        FLUSH,
        DONE
    } gen_state_t;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO: register storage, wrap-bit pointers, registered read port.
// Write while full is accepted only when a read retires a word in the same cycle.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                    (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level  = wr_ptr - rd_ptr;
    // No bypass: a read needs a word that was already stored before this edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Storage write; left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    // Pointer advance and registered read data / valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_top.sv
// Self-exercising FIFO: generator runs fill / drain / stream / flush after reset.
// Optional data checker enabled by defining FIFO_TOP_SELFCHECK_EN; without it
// fail is tied low and only the read count gates done.
module fifo_top
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_WORDS = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            done,
    output logic            fail,
    output logic [ADDR_W:0] level
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    gen_state_t        state, state_nx;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  exp;
    logic              wcnt_inc;
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full, empty;

    fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Generator state and write counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            if (wcnt_inc)
                wcnt <= wcnt + 1'b1;
        end
    end

    // Generator next state and FIFO requests; the overflow and underflow
    // probes are issued once each on the cycle that leaves FILL / DRAIN.
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = DATA_W'(wcnt);
        wcnt_inc = 1'b0;
        unique case (state)
            IDLE:   state_nx = FILL;
            FILL: begin
                wr_en = 1'b1;
                if (!full) begin
                    wcnt_inc = 1'b1;
                end else begin
                    wr_data  = '1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                rd_en = 1'b1;
                if (empty)
                    state_nx = STREAM;
            end
            STREAM: begin
                if (wcnt == CNT_W'(NUM_WORDS)) begin
                    state_nx = FLUSH;
                end else begin
                    wr_en    = 1'b1;
                    rd_en    = 1'b1;
                    wcnt_inc = 1'b1;
                end
            end
            FLUSH: begin
                if (!empty)
                    rd_en = 1'b1;
                else
                    state_nx = DONE;
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef FIFO_TOP_SELFCHECK_EN
    logic fail_q;

    // Checker: compare every returned word with the running expected count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp    <= '0;
            fail_q <= 1'b0;
        end else if (rd_valid) begin
            if (rd_data != DATA_W'(exp))
                fail_q <= 1'b1;
            exp <= exp + 1'b1;
        end
    end

    assign fail = fail_q;
`else
    logic unused_rd_data;

    // Without the checker exp only counts returned words.
    always_ff @(posedge clk) begin
        if (!reset_n)
            exp <= '0;
        else if (rd_valid)
            exp <= exp + 1'b1;
    end

    assign unused_rd_data = ^rd_data;
    assign fail           = 1'b0;
`endif

    // DONE is terminal and nothing writes after it, so done stays high.
    assign done = (state == DONE) && empty && (exp == CNT_W'(NUM_WORDS));

endmodule

// File: tb/tb_fifo_top.sv
// Bench for fifo_top: queue-based model of the generator run, random reset
// points (initial hold, mid-stream, anywhere), per-cycle output comparison.
module tb_fifo_top;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int NUM    = 64;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic            done;
    logic            fail;
    logic [ADDR_W:0] level;

    always #5 clk = ~clk;

    fifo_top #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .done    (done),
        .fail    (fail),
        .level   (level)
    );

    typedef enum int {M_IDLE, M_FILL, M_DRAIN, M_STREAM, M_FLUSH, M_DONE} ph_t;

    ph_t ph       = M_IDLE;
    int  q[$];
    int  wn       = 0;
    bit  m_vld    = 0;
    int  m_data   = 0;
    int  m_rdcnt  = 0;
    bit  m_fail   = 0;
    bit  chk_data = 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit exp_done();
        return (ph == M_DONE) && (q.size() == 0) && (m_rdcnt == NUM);
    endfunction

    // Advance the model by one clock edge.
    task automatic model_step(input bit rst);
        if (!rst) begin
            ph = M_IDLE; q.delete(); wn = 0;
            m_vld = 0; m_data = 0; m_rdcnt = 0; m_fail = 0;
            return;
        end
        if (m_vld) m_rdcnt++;
        m_vld = 0;
        case (ph)
            M_IDLE:  ph = M_FILL;
            M_FILL:  if (q.size() < DEPTH) begin q.push_back(wn % 256); wn++; end
                     else ph = M_DRAIN;
            M_DRAIN: if (q.size() > 0) begin m_data = q.pop_front(); m_vld = 1; end
                     else ph = M_STREAM;
            M_STREAM: if (wn == NUM) ph = M_FLUSH;
                      else begin
                          if (q.size() > 0) begin m_data = q.pop_front(); m_vld = 1; end
                          q.push_back(wn % 256); wn++;
                      end
            M_FLUSH: if (q.size() > 0) begin m_data = q.pop_front(); m_vld = 1; end
                     else ph = M_DONE;
            default: ;
        endcase
    endtask

    task automatic tick(input bit rst);
        @(negedge clk);
        reset_n = rst;
        model_step(rst);
        @(posedge clk);
        #1;
        check("level",    32'(level),             32'(q.size()));
        check("done",     32'(done),              32'(exp_done()));
        check("fail",     32'(fail),              32'(m_fail));
        check("rd_valid", 32'(dut.rd_valid),      32'(m_vld));
        check("full",     32'(dut.u_fifo.full),   32'(q.size() == DEPTH));
        if (chk_data)
            check("rd_data", 32'(dut.rd_data), 32'(m_data));
    endtask

    task automatic run_to_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("done_latency_le_90", 32'(n <= 90), 32'd1);
    endtask

    initial begin
        int k;

        // Power-on reset, random hold, full run, linger in DONE.
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) tick(0);
        run_to_done();
        k = $urandom_range(3, 10);
        for (int i = 0; i < k; i++) tick(1);

        // Reset during STREAM, then rerun.
        tick(0);
        k = $urandom_range(40, 80);
        for (int i = 0; i < k; i++) tick(1);
        k = $urandom_range(1, 2);
        for (int i = 0; i < k; i++) tick(0);
        run_to_done();

        // Reset at an arbitrary point of the run, then rerun.
        tick(0);
        k = $urandom_range(1, 85);
        for (int i = 0; i < k; i++) tick(1);
        tick(0);
        run_to_done();

`ifdef FIFO_TOP_SELFCHECK_EN
        // Corrupt one returned word and expect the checker to latch fail.
        begin
            int n = 0;
            chk_data = 0;
            tick(0);
            while (dut.rd_valid !== 1'b1 && n < 40) begin
                tick(1);
                n++;
            end
            check("rd_valid_seen", 32'(dut.rd_valid), 32'd1);
            force dut.rd_data = 8'hA5;
            m_fail = 1;
            tick(1);
            release dut.rd_data;
            tick(1);
            tick(0);
            chk_data = 1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
